bcd_stopwatch_n: RTL and testbench

Parametrised N-digit BCD stopwatch core, the successor to the fixed two-digit stopwatch top. It takes raw one/ten/pause/clear push-buttons and synchronises and debounces them on-chip. It counts in 1s or 10s per tick and drives a packed BCD count, per-digit 7-segment patterns and a one-hot state vector. It adds configurable digit count, tick period and debounce length, plus a selectable wrap or saturate-and-stop overflow policy.

---
 rtl/bcd_stopwatch_n.sv | 161 ++++++++++++++++
 tb/tb_bcd_stopwatch_n.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_n.sv
// N-digit BCD stopwatch: debounced one/ten/pause/clear buttons, one-hot FSM,
// tick prescaler, BCD counter with wrap or saturate overflow, 7-seg decode.
module bcd_stopwatch_n #(
  parameter int DIGITS          = 4,
  parameter int TICK_CYCLES     = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000,
  parameter int WRAP            = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  one_button,
  input  logic                  ten_button,
  input  logic                  pause_button,
  input  logic                  clear_button,
  output logic [4*DIGITS-1:0]   bcd_num,
  output logic [7*DIGITS-1:0]   seg,
  output logic [4:0]            fsm_state,
  output logic                  tick,
  output logic                  overflow
);

  localparam int PW = $clog2(TICK_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    RUN1  = 5'b00010,
    RUN10 = 5'b00100,
    PAUSE = 5'b01000,
    DONE  = 5'b10000
  } state_t;

  state_t                       state;
  logic [PW-1:0]                pre;
  logic [DIGITS-1:0][3:0]       digits;
  logic [DIGITS-1:0][3:0]       nxt;
  logic                         inc_c;
  logic                         running;

  // Button order everywhere: [0] one, [1] ten, [2] pause, [3] clear
  logic [3:0]                   raw, s1, s2, evt;
  logic [3:0][DW-1:0]           db_cnt;
  logic                         ev_clr, ev_pause, ev_ten, ev_one;

  assign raw = {clear_button, pause_button, ten_button, one_button};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      db_cnt <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int b = 0; b < 4; b++) begin
        if (!s2[b])
          db_cnt[b] <= '0;
        else if (db_cnt[b] != DW'(DEBOUNCE_CYCLES))
          db_cnt[b] <= db_cnt[b] + DW'(1);
      end
    end
  end

  // Counter parks at DEBOUNCE_CYCLES while held, so a hold fires exactly once.
  always_comb begin
    evt = '0;
    for (int b = 0; b < 4; b++)
      evt[b] = s2[b] && (db_cnt[b] == DW'(DEBOUNCE_CYCLES - 1));
  end

  assign ev_clr   = evt[3];
  assign ev_pause = evt[2] && !evt[3];
  assign ev_ten   = evt[1] && !(|evt[3:2]);
  assign ev_one   = evt[0] && !(|evt[3:1]);

  assign running   = (state == RUN1) || (state == RUN10);
  assign tick      = running && (pre == PW'(TICK_CYCLES - 1));
  assign fsm_state = state;
  assign bcd_num   = digits;

  // Decimal increment; RUN10 injects the carry at digit 1.
  always_comb begin
    inc_c = 1'b1;
    nxt   = digits;
    for (int k = 0; k < DIGITS; k++) begin
      if (!(k == 0 && state == RUN10) && inc_c) begin
        if (digits[k] == 4'd9)
          nxt[k] = 4'd0;
        else begin
          nxt[k] = digits[k] + 4'd1;
          inc_c  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      digits   <= '0;
      pre      <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (running)
        pre <= tick ? '0 : pre + PW'(1);
      else if (state == IDLE)
        pre <= '0;

      unique case (state)
        IDLE:    if (ev_ten) state <= RUN10; else if (ev_one) state <= RUN1;
        RUN1:    if (ev_pause) state <= PAUSE; else if (ev_ten) state <= RUN10;
        RUN10:   if (ev_pause) state <= PAUSE; else if (ev_one) state <= RUN1;
        PAUSE:   if (ev_ten) state <= RUN10; else if (ev_one) state <= RUN1;
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase

      // A pause or clear landing on a tick swallows that tick's increment.
      if (tick && !ev_clr && !ev_pause) begin
        digits <= nxt;
        if (inc_c) begin
          overflow <= 1'b1;
          if (WRAP == 0) begin
            digits <= {DIGITS{4'd9}};
            state  <= DONE;
          end
        end
      end

      if (ev_clr) begin
        state  <= IDLE;
        digits <= '0;
        pre    <= '0;
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  always_comb begin
    seg = '0;
    for (int k = 0; k < DIGITS; k++)
      seg[7*k +: 7] = seg7(digits[k]);
  end

endmodule

// File: tb/tb_bcd_stopwatch_n.sv
// Three stopwatch instances (2-digit wrap, 2-digit saturate, 4-digit wrap) on
// shared buttons, each checked every cycle against an integer-count model.
module tb_bcd_stopwatch_n;
  localparam int T = 10;
  localparam int D = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic btn_one = 1'b0, btn_ten = 1'b0, btn_pause = 1'b0, btn_clear = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  bcd_a, bcd_b;
  logic [15:0] bcd_c;
  logic [13:0] seg_a, seg_b;
  logic [27:0] seg_c;
  logic [4:0]  fsm_a, fsm_b, fsm_c;
  logic        tick_a, tick_b, tick_c, ovf_a, ovf_b, ovf_c;

  bcd_stopwatch_n #(.DIGITS(2), .TICK_CYCLES(T), .DEBOUNCE_CYCLES(D), .WRAP(1)) u_a (
    .clk(clk), .rst(rst), .one_button(btn_one), .ten_button(btn_ten),
    .pause_button(btn_pause), .clear_button(btn_clear), .bcd_num(bcd_a),
    .seg(seg_a), .fsm_state(fsm_a), .tick(tick_a), .overflow(ovf_a));
  bcd_stopwatch_n #(.DIGITS(2), .TICK_CYCLES(T), .DEBOUNCE_CYCLES(D), .WRAP(0)) u_b (
    .clk(clk), .rst(rst), .one_button(btn_one), .ten_button(btn_ten),
    .pause_button(btn_pause), .clear_button(btn_clear), .bcd_num(bcd_b),
    .seg(seg_b), .fsm_state(fsm_b), .tick(tick_b), .overflow(ovf_b));
  bcd_stopwatch_n #(.DIGITS(4), .TICK_CYCLES(T), .DEBOUNCE_CYCLES(D), .WRAP(1)) u_c (
    .clk(clk), .rst(rst), .one_button(btn_one), .ten_button(btn_ten),
    .pause_button(btn_pause), .clear_button(btn_clear), .bcd_num(bcd_c),
    .seg(seg_c), .fsm_state(fsm_c), .tick(tick_c), .overflow(ovf_c));

  // Model: states 0 IDLE, 1 RUN1, 2 RUN10, 3 PAUSE, 4 DONE; count held as an integer.
  int m_st[3], m_cnt[3], m_pre[3];
  bit m_ovf[3];
  int n_dig[3] = '{2, 2, 4};
  int n_wrap[3] = '{1, 0, 1};
  bit dly0[4], dly1[4], ev[4];
  int streak[4];
  int vecs = 0, errs = 0;
  logic [6:0] seg_tab[10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                              7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pow10(input int n);
    int r = 1;
    for (int k = 0; k < n; k++) r *= 10;
    return r;
  endfunction

  function automatic logic [63:0] exp_bcd(input int v, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r |= 64'((v / pow10(k)) % 10) << (4 * k);
    return r;
  endfunction

  function automatic logic [63:0] exp_seg(input int v, input int n);
    logic [63:0] r = '0;
    for (int k = 0; k < n; k++) r[7*k +: 7] = seg_tab[(v / pow10(k)) % 10];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_cnt[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
    end
    for (int b = 0; b < 4; b++) begin
      dly0[b] = 0; dly1[b] = 0; streak[b] = 0; ev[b] = 0;
    end
  endtask

  // Event = raw seen high for exactly D consecutive samples, two samples late.
  task automatic model_edge();
    bit rawv[4];
    int w, nst, inc, lim;
    bit run, tk;
    rawv = '{btn_one, btn_ten, btn_pause, btn_clear};
    for (int b = 0; b < 4; b++) begin
      if (dly1[b]) begin if (streak[b] < 1000) streak[b]++; end
      else streak[b] = 0;
      ev[b] = dly1[b] && (streak[b] == D);
      dly1[b] = dly0[b];
      dly0[b] = rawv[b];
    end
    w = ev[3] ? 3 : ev[2] ? 2 : ev[1] ? 1 : ev[0] ? 0 : -1;
    for (int i = 0; i < 3; i++) begin
      run = (m_st[i] == 1) || (m_st[i] == 2);
      tk  = run && (m_pre[i] == T - 1);
      nst = m_st[i];
      m_ovf[i] = 0;
      if (run) m_pre[i] = tk ? 0 : m_pre[i] + 1;
      else if (m_st[i] == 0) m_pre[i] = 0;
      case (w)
        0: if (m_st[i] == 0 || m_st[i] == 2 || m_st[i] == 3) nst = 1;
        1: if (m_st[i] == 0 || m_st[i] == 1 || m_st[i] == 3) nst = 2;
        2: if (run) nst = 3;
        default: ;
      endcase
      if (tk && w != 3 && w != 2) begin
        inc = (m_st[i] == 1) ? 1 : 10;
        lim = pow10(n_dig[i]);
        if (m_cnt[i] + inc >= lim) begin
          m_ovf[i] = 1;
          if (n_wrap[i] != 0) m_cnt[i] = (m_cnt[i] + inc) % lim;
          else begin m_cnt[i] = lim - 1; nst = 4; end
        end else m_cnt[i] += inc;
      end
      if (w == 3) begin nst = 0; m_cnt[i] = 0; m_pre[i] = 0; end
      m_st[i] = nst;
    end
  endtask

  task automatic check_all();
    logic [63:0] gb[3], gs[3], gf[3], gt[3], go[3];
    bit run;
    gb = '{64'(bcd_a), 64'(bcd_b), 64'(bcd_c)};
    gs = '{64'(seg_a), 64'(seg_b), 64'(seg_c)};
    gf = '{64'(fsm_a), 64'(fsm_b), 64'(fsm_c)};
    gt = '{64'(tick_a), 64'(tick_b), 64'(tick_c)};
    go = '{64'(ovf_a), 64'(ovf_b), 64'(ovf_c)};
    for (int i = 0; i < 3; i++) begin
      run = (m_st[i] == 1) || (m_st[i] == 2);
      chk($sformatf("u%0d.state", i), gf[i], 64'(1) << m_st[i]);
      chk($sformatf("u%0d.bcd", i), gb[i], exp_bcd(m_cnt[i], n_dig[i]));
      chk($sformatf("u%0d.seg", i), gs[i], exp_seg(m_cnt[i], n_dig[i]));
      chk($sformatf("u%0d.tick", i), gt[i], 64'(run && m_pre[i] == T - 1));
      chk($sformatf("u%0d.ovf", i), go[i], 64'(m_ovf[i]));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_btn(input logic [3:0] m);
    {btn_clear, btn_pause, btn_ten, btn_one} = m;
  endtask

  task automatic press(input logic [3:0] m, input int hold, input int gap);
    set_btn(m);
    repeat (hold) cyc();
    set_btn(4'b0000);
    repeat (gap) cyc();
  endtask

  initial begin
    model_reset();
    repeat (3) cyc();
    chk("reset.seg", 64'(seg_c), 64'h0fdf_bf7e_fdfb_f & 64'hfff_ffff | 64'(28'b0111111_0111111_0111111_0111111));
    rst = 1'b0;
    repeat (2) cyc();

    // Press one: state must change exactly 2 + D edges after the rise.
    set_btn(4'b0001);
    repeat (5) cyc();
    chk("lat.before", 64'(fsm_a), 64'(5'b00001));
    cyc();
    chk("lat.after", 64'(fsm_a), 64'(5'b00010));
    repeat (14) cyc();
    set_btn(4'b0000);
    repeat (40) cyc();
    chk("five.bcd", 64'(bcd_a), 64'h05);
    chk("five.seg", 64'(seg_a[6:0]), 64'(7'b1101101));

    // This pause event lands on a tick: increment is dropped.
    press(4'b0100, 8, 50);
    chk("pause.bcd", 64'(bcd_a), 64'h05);
    chk("pause.state", 64'(fsm_a), 64'(5'b01000));
    press(4'b0001, 8, 30);

    // Ten ticks in RUN10 wrap 2 digits, saturate the WRAP=0 instance.
    press(4'b1000, 8, 5);
    press(4'b0010, 8, 98);
    chk("ten.bcd_a", 64'(bcd_a), 64'h00);
    chk("ten.ovf_a", 64'(ovf_a), 64'h1);
    chk("ten.fsm_a", 64'(fsm_a), 64'(5'b00100));
    chk("ten.bcd_b", 64'(bcd_b), 64'h99);
    chk("ten.fsm_b", 64'(fsm_b), 64'(5'b10000));
    chk("ten.bcd_c", 64'(bcd_c), 64'h0100);
    press(4'b0001, 6, 10);
    press(4'b0010, 6, 10);
    press(4'b0100, 6, 10);
    chk("done.hold", 64'(fsm_b), 64'(5'b10000));

    // 4-digit ones carry: 0090 in RUN10, then RUN1 through 0099 -> 0100.
    press(4'b1000, 8, 5);
    press(4'b0010, 8, 88);
    press(4'b0001, 8, 95);
    chk("carry.bcd_c", 64'(bcd_c), 64'h0100);

    // Glitch, long hold, simultaneous clear+one.
    press(4'b1000, 8, 5);
    press(4'b0001, 3, 20);
    chk("glitch", 64'(fsm_a), 64'(5'b00001));
    press(4'b0001, 100, 10);
    press(4'b1001, 8, 10);
    chk("clr.wins", 64'(fsm_a), 64'(5'b00001));

    for (int it = 0; it < 150; it++) begin
      int r;
      logic [3:0] m;
      r = $urandom_range(0, 9);
      m = (r < 3) ? 4'b0001 : (r < 6) ? 4'b0010 : (r < 8) ? 4'b0100 :
          (r == 8) ? 4'b1000 : 4'($urandom_range(1, 15));
      press(m, $urandom_range(1, 12), $urandom_range(0, 40));
    end

    // Async reset between edges while running in RUN10.
    press(4'b1000, 8, 5);
    press(4'b0010, 8, 30);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all();
    chk("arst.fsm", 64'(fsm_c), 64'(5'b00001));
    repeat (2) cyc();
    rst = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
